// File: rtl/activation_arbiter.sv
// Round-robin arbiter sharing one activation unit among N requesters.
// Ports: clk/rst; per-requester arg/err in, res/fbk out; act_* unit streams.
module activation_arbiter #(
   parameter int N     = 4,
   parameter int ARG_W = 16,
   parameter int RES_W = 8,
   parameter int ERR_W = 16,
   parameter int FBK_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       req_arg_stb,
   output logic [N-1:0]       req_arg_rdy,
   input  logic [N*ARG_W-1:0] req_arg_dat,
   input  logic [N-1:0]       req_err_stb,
   output logic [N-1:0]       req_err_rdy,
   input  logic [N*ERR_W-1:0] req_err_dat,
   output logic [N-1:0]       req_res_stb,
   input  logic [N-1:0]       req_res_rdy,
   output logic [RES_W-1:0]   req_res_dat,
   output logic [N-1:0]       req_fbk_stb,
   input  logic [N-1:0]       req_fbk_rdy,
   output logic [FBK_W-1:0]   req_fbk_dat,
   output logic               act_arg_stb,
   input  logic               act_arg_rdy,
   output logic [ARG_W-1:0]   act_arg_dat,
   input  logic               act_res_stb,
   output logic               act_res_rdy,
   input  logic [RES_W-1:0]   act_res_dat,
   output logic               act_err_stb,
   input  logic               act_err_rdy,
   output logic [ERR_W-1:0]   act_err_dat,
   input  logic               act_fbk_stb,
   output logic               act_fbk_rdy,
   input  logic [FBK_W-1:0]   act_fbk_dat
);

   localparam int GW  = $clog2(N);
   localparam int OPW = (ARG_W > ERR_W) ? ARG_W : ERR_W;
   localparam int RSW = (RES_W > FBK_W) ? RES_W : FBK_W;

   typedef enum logic [1:0] {IDLE, SEND, WAIT, RETURN} state_t;

   state_t         state;
   logic [GW-1:0]  g;
   logic [GW-1:0]  p;
   logic           bwd;
   logic [OPW-1:0] opnd;
   logic [RSW-1:0] rslt;

   logic           found;
   logic [GW-1:0]  sel;
   logic           sel_bwd;
   logic [ARG_W-1:0] sel_arg;
   logic [ERR_W-1:0] sel_err;

   // Scan from p upward with wrap; first pending requester wins.
   always_comb begin
      int j;
      found = 1'b0;
      sel   = '0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(p) + k;
         if (j >= N) j = j - N;
         if (!found && (req_arg_stb[j] || req_err_stb[j])) begin
            found = 1'b1;
            sel   = GW'(j);
         end
      end
      sel_bwd = req_err_stb[sel];
      sel_arg = req_arg_dat[int'(sel)*ARG_W +: ARG_W];
      sel_err = req_err_dat[int'(sel)*ERR_W +: ERR_W];
   end

   wire take = (state == IDLE) && found;

   assign req_arg_rdy = (take && !sel_bwd) ? (N'(1) << sel) : '0;
   assign req_err_rdy = (take &&  sel_bwd) ? (N'(1) << sel) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         g     <= '0;
         p     <= '0;
         bwd   <= 1'b0;
         opnd  <= '0;
         rslt  <= '0;
      end else begin
         unique case (state)
            IDLE: if (found) begin
               g     <= sel;
               bwd   <= sel_bwd;
               opnd  <= sel_bwd ? OPW'(sel_err) : OPW'(sel_arg);
               state <= SEND;
            end
            SEND: if (bwd ? act_err_rdy : act_arg_rdy)
               state <= WAIT;
            WAIT: begin
               if (!bwd && act_res_stb) begin
                  rslt  <= RSW'(act_res_dat);
                  state <= RETURN;
               end else if (bwd && act_fbk_stb) begin
                  rslt  <= RSW'(act_fbk_dat);
                  state <= RETURN;
               end
            end
            RETURN: if (bwd ? req_fbk_rdy[g] : req_res_rdy[g]) begin
               p     <= (int'(g) == N-1) ? '0 : g + GW'(1);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode straight from registered state.
   assign act_arg_stb = (state == SEND) && !bwd;
   assign act_err_stb = (state == SEND) &&  bwd;
   assign act_arg_dat = opnd[ARG_W-1:0];
   assign act_err_dat = opnd[ERR_W-1:0];
   assign act_res_rdy = (state == WAIT) && !bwd;
   assign act_fbk_rdy = (state == WAIT) &&  bwd;

   assign req_res_stb = (state == RETURN && !bwd) ? (N'(1) << g) : '0;
   assign req_fbk_stb = (state == RETURN &&  bwd) ? (N'(1) << g) : '0;
   assign req_res_dat = rslt[RES_W-1:0];
   assign req_fbk_dat = rslt[FBK_W-1:0];

endmodule

// File: tb/tb_activation_arbiter.sv
// Directed bench for activation_arbiter with a stalling stub unit.
// Stub: res = arg[7:0]^8'h5a, fbk = err+1, k-cycle programmable stall.
module tb_activation_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  arg_stb = '0, arg_rdy, err_stb = '0, err_rdy;
   logic [63:0] arg_dat = '0, err_dat = '0;
   logic [3:0]  res_stb, res_rdy = '1, fbk_stb, fbk_rdy = '1;
   logic [7:0]  res_dat;
   logic [15:0] fbk_dat;
   logic        a_arg_stb, a_arg_rdy, a_res_stb, a_res_rdy;
   logic        a_err_stb, a_err_rdy, a_fbk_stb, a_fbk_rdy;
   logic [15:0] a_arg_dat, a_err_dat, a_fbk_dat;
   logic [7:0]  a_res_dat;

   always #5 clk = ~clk;

   activation_arbiter dut (
      .clk(clk), .rst(rst),
      .req_arg_stb(arg_stb), .req_arg_rdy(arg_rdy), .req_arg_dat(arg_dat),
      .req_err_stb(err_stb), .req_err_rdy(err_rdy), .req_err_dat(err_dat),
      .req_res_stb(res_stb), .req_res_rdy(res_rdy), .req_res_dat(res_dat),
      .req_fbk_stb(fbk_stb), .req_fbk_rdy(fbk_rdy), .req_fbk_dat(fbk_dat),
      .act_arg_stb(a_arg_stb), .act_arg_rdy(a_arg_rdy),
      .act_arg_dat(a_arg_dat),
      .act_res_stb(a_res_stb), .act_res_rdy(a_res_rdy),
      .act_res_dat(a_res_dat),
      .act_err_stb(a_err_stb), .act_err_rdy(a_err_rdy),
      .act_err_dat(a_err_dat),
      .act_fbk_stb(a_fbk_stb), .act_fbk_rdy(a_fbk_rdy),
      .act_fbk_dat(a_fbk_dat)
   );

   // Stub unit: phase 0 accepts an operand, phase 1 offers the answer.
   int          stall = 0;
   int          u_cnt = 0;
   logic        u_ph  = 1'b0;
   logic        u_bwd = 1'b0;
   logic [15:0] u_val = '0;

   assign a_arg_rdy = !u_ph && a_arg_stb && (u_cnt >= stall);
   assign a_err_rdy = !u_ph && a_err_stb && (u_cnt >= stall);
   assign a_res_stb = u_ph && !u_bwd && (u_cnt >= stall);
   assign a_fbk_stb = u_ph &&  u_bwd && (u_cnt >= stall);
   assign a_res_dat = u_val[7:0];
   assign a_fbk_dat = u_val;

   always @(posedge clk) begin
      if (rst) begin
         u_ph  <= 1'b0;
         u_cnt <= 0;
      end else if (!u_ph) begin
         if (a_arg_stb && a_arg_rdy) begin
            u_ph <= 1'b1; u_bwd <= 1'b0; u_cnt <= 0;
            u_val <= {8'h00, a_arg_dat[7:0] ^ 8'h5a};
         end else if (a_err_stb && a_err_rdy) begin
            u_ph <= 1'b1; u_bwd <= 1'b1; u_cnt <= 0;
            u_val <= a_err_dat + 16'd1;
         end else if (a_arg_stb || a_err_stb) begin
            u_cnt <= u_cnt + 1;
         end
      end else begin
         if ((a_res_stb && a_res_rdy) || (a_fbk_stb && a_fbk_rdy)) begin
            u_ph  <= 1'b0;
            u_cnt <= 0;
         end else begin
            u_cnt <= u_cnt + 1;
         end
      end
   end

   int pass_cnt = 0;
   int chk_cnt  = 0;

   int          q_i[$];
   bit          q_b[$];
   logic [15:0] q_d[$];

   logic [3:0]  s_arg_rdy, s_err_rdy, s_res_stb, s_fbk_stb;
   logic [7:0]  s_res_dat;
   logic [15:0] s_fbk_dat, s_act_arg_dat;
   logic        s_act_arg_stb, s_act_err_stb, s_act_res_rdy, s_act_fbk_rdy;

   // One cycle: sample at negedge, log responses, drop accepted stbs.
   task automatic step();
      logic [3:0] ax, ex;
      int ones;
      @(negedge clk);
      s_arg_rdy = arg_rdy; s_err_rdy = err_rdy;
      s_res_stb = res_stb; s_fbk_stb = fbk_stb;
      s_res_dat = res_dat; s_fbk_dat = fbk_dat;
      s_act_arg_stb = a_arg_stb; s_act_arg_dat = a_arg_dat;
      s_act_err_stb = a_err_stb;
      s_act_res_rdy = a_res_rdy; s_act_fbk_rdy = a_fbk_rdy;
      ax = arg_stb & arg_rdy;
      ex = err_stb & err_rdy;
      ones = $countones({arg_rdy, err_rdy, res_stb, fbk_stb});
      chk_cnt++;
      if (ones > 1) $display("FAIL onehot: %0d bits high, need <=1", ones);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         if (res_stb[i] && res_rdy[i]) begin
            q_i.push_back(i); q_b.push_back(1'b0);
            q_d.push_back({8'h00, res_dat});
         end
         if (fbk_stb[i] && fbk_rdy[i]) begin
            q_i.push_back(i); q_b.push_back(1'b1); q_d.push_back(fbk_dat);
         end
      end
      @(posedge clk);
      #1;
      arg_stb = arg_stb & ~ax;
      err_stb = err_stb & ~ex;
   endtask

   task automatic run(input int n, input int budget);
      int c = 0;
      while (q_i.size() < n && c < budget) begin
         step();
         c++;
      end
      chk_cnt++;
      if (q_i.size() < n)
         $display("FAIL timeout: got %0d responses, need %0d", q_i.size(), n);
      else pass_cnt++;
   endtask

   task automatic clr();
      q_i.delete(); q_b.delete(); q_d.delete();
   endtask

   task automatic set_arg(input int i, input logic [15:0] v);
      arg_stb[i] = 1'b1;
      arg_dat[i*16 +: 16] = v;
   endtask

   task automatic set_err(input int i, input logic [15:0] v);
      err_stb[i] = 1'b1;
      err_dat[i*16 +: 16] = v;
   endtask

   task automatic chk_resp(input string nm, input int k, input int i,
                           input bit b, input logic [15:0] d);
      chk_cnt++;
      if (q_i.size() <= k || q_i[k] != i || q_b[k] != b || q_d[k] !== d)
         $display("FAIL %s: resp %0d got i=%0d b=%0d d=%h, need i=%0d b=%0d d=%h",
                  nm, k, (q_i.size() > k) ? q_i[k] : -1,
                  (q_b.size() > k) ? q_b[k] : 1'b0,
                  (q_d.size() > k) ? q_d[k] : 16'hxxxx, i, b, d);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      chk_cnt++;
      if ({s_arg_rdy, s_err_rdy, s_res_stb, s_fbk_stb} !== 16'h0 ||
          {s_act_arg_stb, s_act_err_stb, s_act_res_rdy, s_act_fbk_rdy} !== 4'h0)
         $display("FAIL reset_outs: rdy/stb=%h act=%b, need 0",
                  {s_arg_rdy, s_err_rdy, s_res_stb, s_fbk_stb},
                  {s_act_arg_stb, s_act_err_stb, s_act_res_rdy, s_act_fbk_rdy});
      else pass_cnt++;
      chk_cnt++;
      if (s_res_dat !== 8'h00 || s_act_arg_dat !== 16'h0)
         $display("FAIL reset_regs: res=%h op=%h, need 0", s_res_dat, s_act_arg_dat);
      else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_latency();
      clr();
      set_arg(2, 16'h0011);
      step();
      chk_cnt++;
      if (s_arg_rdy !== 4'b0100 || s_err_rdy !== 4'b0000)
         $display("FAIL accept: arg_rdy=%b err_rdy=%b, need 0100/0000",
                  s_arg_rdy, s_err_rdy);
      else pass_cnt++;
      step();
      chk_cnt++;
      if (s_act_arg_stb !== 1'b1 || s_act_arg_dat !== 16'h0011)
         $display("FAIL send: stb=%b dat=%h, need 1/0011", s_act_arg_stb, s_act_arg_dat);
      else pass_cnt++;
      step();
      chk_cnt++;
      if (s_act_res_rdy !== 1'b1 || s_act_fbk_rdy !== 1'b0)
         $display("FAIL wait: res_rdy=%b fbk_rdy=%b, need 1/0",
                  s_act_res_rdy, s_act_fbk_rdy);
      else pass_cnt++;
      step();
      chk_cnt++;
      if (s_res_stb !== 4'b0100 || s_res_dat !== 8'h4b)
         $display("FAIL ret3: stb=%b dat=%h, need 0100/4b", s_res_stb, s_res_dat);
      else pass_cnt++;
      chk_resp("t1_resp", 0, 2, 1'b0, 16'h004b);
      // p should now be 3: with 2 and 3 both pending, 3 goes first.
      clr();
      set_arg(2, 16'h0000);
      set_arg(3, 16'h0001);
      run(2, 30);
      chk_resp("ptr3_a", 0, 3, 1'b0, 16'h005b);
      chk_resp("ptr3_b", 1, 2, 1'b0, 16'h005a);
   endtask

   task automatic test_backward();
      clr();
      set_err(1, 16'hffff);
      run(1, 20);
      repeat (3) step();
      chk_resp("bwd", 0, 1, 1'b1, 16'h0000);
      chk_cnt++;
      if (q_i.size() != 1)
         $display("FAIL bwd_count: %0d responses, need 1", q_i.size());
      else pass_cnt++;
   endtask

   task automatic test_round_robin();
      logic [15:0] ex[4];
      ex[0] = 16'h004a; ex[1] = 16'h007b; ex[2] = 16'h0068; ex[3] = 16'h0019;
      // p=2 after requester 1; serving 3 brings it to 0.
      clr();
      set_arg(3, 16'h0000);
      run(1, 20);
      clr();
      set_arg(0, 16'h0010); set_arg(1, 16'h0021);
      set_arg(2, 16'h0032); set_arg(3, 16'h0043);
      run(4, 60);
      for (int k = 0; k < 4; k++) chk_resp("rr_p0", k, k, 1'b0, ex[k]);
      clr();
      set_arg(2, 16'h0000);
      run(1, 20);
      clr();
      set_arg(0, 16'h0010); set_arg(1, 16'h0021);
      set_arg(2, 16'h0032); set_arg(3, 16'h0043);
      run(4, 60);
      for (int k = 0; k < 4; k++)
         chk_resp("rr_p3", k, (k + 3) % 4, 1'b0, ex[(k + 3) % 4]);
   endtask

   task automatic test_err_priority();
      clr();
      set_arg(0, 16'h000f);
      set_err(0, 16'h1234);
      run(2, 40);
      repeat (3) step();
      chk_resp("prio_err", 0, 0, 1'b1, 16'h1235);
      chk_resp("prio_arg", 1, 0, 1'b0, 16'h0055);
      chk_cnt++;
      if (q_i.size() != 2)
         $display("FAIL prio_count: %0d responses, need 2", q_i.size());
      else pass_cnt++;
   endtask

   task automatic test_back_to_back_stall();
      int c = 0;
      clr();
      stall = 5;
      res_rdy = 4'b0000;
      set_arg(1, 16'h0077);
      set_arg(3, 16'h0088);
      step();
      while (s_res_stb == 4'b0000 && c < 40) begin
         step();
         c++;
      end
      chk_cnt++;
      if (s_res_stb !== 4'b0010 || s_res_dat !== 8'h2d)
         $display("FAIL stall_ret: stb=%b dat=%h, need 0010/2d", s_res_stb, s_res_dat);
      else pass_cnt++;
      repeat (4) begin
         step();
         chk_cnt++;
         if (s_res_stb !== 4'b0010 || s_res_dat !== 8'h2d || s_arg_rdy !== 4'b0)
            $display("FAIL stall_hold: stb=%b dat=%h rdy=%b, need 0010/2d/0000",
                     s_res_stb, s_res_dat, s_arg_rdy);
         else pass_cnt++;
      end
      res_rdy = 4'b1111;
      run(2, 60);
      chk_resp("stall_1", 0, 1, 1'b0, 16'h002d);
      chk_resp("stall_3", 1, 3, 1'b0, 16'h00d2);
      stall = 0;
   endtask

   task automatic test_mid_reset();
      int c = 0;
      clr();
      stall = 3;
      set_arg(0, 16'h00aa);
      step();
      while (!s_act_res_rdy && c < 30) begin
         step();
         c++;
      end
      chk_cnt++;
      if (!s_act_res_rdy) $display("FAIL reach_wait: act_res_rdy=0, need 1");
      else pass_cnt++;
      rst = 1'b1;
      step();
      step();
      chk_cnt++;
      if ({s_arg_rdy, s_err_rdy, s_res_stb, s_fbk_stb} !== 16'h0 ||
          {s_act_arg_stb, s_act_err_stb, s_act_res_rdy, s_act_fbk_rdy} !== 4'h0)
         $display("FAIL midrst: rdy/stb=%h act=%b, need 0",
                  {s_arg_rdy, s_err_rdy, s_res_stb, s_fbk_stb},
                  {s_act_arg_stb, s_act_err_stb, s_act_res_rdy, s_act_fbk_rdy});
      else pass_cnt++;
      rst = 1'b0;
      stall = 0;
      repeat (3) step();
      chk_cnt++;
      if (q_i.size() != 0)
         $display("FAIL midrst_drop: %0d responses, need 0", q_i.size());
      else pass_cnt++;
      set_arg(2, 16'h0011);
      run(1, 20);
      chk_resp("midrst_new", 0, 2, 1'b0, 16'h004b);
   endtask

   initial begin
      #1;
      test_reset();
      test_latency();
      test_backward();
      test_round_robin();
      test_err_priority();
      test_back_to_back_stall();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/activation_arbiter.md
Name: activation_arbiter

Overview:
- Shares one activation unit (heaviside or any unit with the same forward/backward stream interface) among N requesters, e.g. the neurons of one layer.
- Accepts a forward argument or a backward error from one requester and forwards it to the unit.
- Captures the unit's result or feedback and returns it to that requester only.
- One transaction is in flight at a time. Grants are round-robin across requesters.

Parameters:
N, 4, number of requesters (2..16)
ARG_W, 16, argument width
RES_W, 8, result width
ERR_W, 16, error width
FBK_W, 16, feedback width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_arg_stb  in  N  per-requester argument valid
req_arg_rdy  out  N  per-requester argument accept
req_arg_dat  in  N*ARG_W  arguments, requester i at [i*ARG_W +: ARG_W]
req_err_stb  in  N  per-requester error valid
req_err_rdy  out  N  per-requester error accept
req_err_dat  in  N*ERR_W  errors, packed as for req_arg_dat
req_res_stb  out  N  per-requester result valid
req_res_rdy  in  N  per-requester result accept
req_res_dat  out  RES_W  result, shared bus, qualified by req_res_stb
req_fbk_stb  out  N  per-requester feedback valid
req_fbk_rdy  in  N  per-requester feedback accept
req_fbk_dat  out  FBK_W  feedback, shared bus, qualified by req_fbk_stb
act_arg_stb/act_arg_rdy/act_arg_dat  out/in/out  1/1/ARG_W  argument stream to unit
act_res_stb/act_res_rdy/act_res_dat  in/out/in  1/1/RES_W  result stream from unit
act_err_stb/act_err_rdy/act_err_dat  out/in/out  1/1/ERR_W  error stream to unit
act_fbk_stb/act_fbk_rdy/act_fbk_dat  in/out/in  1/1/FBK_W  feedback stream from unit

Behaviour:
- Handshake on every stream: a transfer occurs on a cycle where stb and rdy are both high at the rising edge of clk.
- Senders hold stb and dat stable until the transfer occurs.
- FSM states: IDLE, SEND, WAIT, RETURN. Registers:
  - grant index g
  - op flag (FWD or BWD)
  - operand register
  - result register
  - round-robin pointer p
- IDLE:
  - req[i] = req_arg_stb[i] | req_err_stb[i].
  - g = first i with req[i] set, scanning p, p+1, ..., wrapping mod N.
  - Within requester g, the error beats the argument (op=BWD when req_err_stb[g]=1).
  - Combinationally assert the single matching req_*_rdy[g] in that same cycle. The transfer completes and the operand is captured.
  - Next state is SEND. With no requests, stay in IDLE and keep all rdy low.
- SEND: drive act_arg_stb (FWD) or act_err_stb (BWD) high with the operand register on the matching dat bus. Go to WAIT on the cycle the unit accepts.
- WAIT:
  - Hold act_res_rdy (FWD) or act_fbk_rdy (BWD) high and capture act_*_dat on transfer. Go to RETURN.
  - Ignore the non-matching unit output stream; its rdy stays low.
- RETURN:
  - Drive req_res_stb[g] (FWD) or req_fbk_stb[g] (BWD) high and the result register on the shared dat bus.
  - On transfer: p <= (g+1) mod N, then go to IDLE.
- Minimum latency from request accept to result valid is 3 cycles with a zero-wait unit. Throughput is at most one transaction per 4 cycles.
- No req_*_rdy is high outside IDLE. At most one bit of all req_*_stb / req_*_rdy outputs is high in any cycle.
- A requester that drops its request while not granted is legal and is skipped. Grant depends only on the stb values in the IDLE cycle.
- Shared dat buses are don't-care when no stb is high. Implementations drive the result register.
- Reset values:
  - state IDLE, p=0, g=0
  - all req_*_rdy, req_*_stb, act_*_stb and act_*_rdy low
  - operand and result registers zero
- Reset mid-operation: the in-flight transaction is abandoned with no result returned. Outputs are at reset values from the cycle after rst is sampled high. A unit still holding a result is not drained; the integrator resets the unit with the same rst.
- The unit's en input is not driven here.

Test Plan:
Bench uses a stub unit: res = arg[7:0]^8'h5a, fbk = err+1, with a programmable stall of k cycles before asserting rdy/stb.

1. Reset, then requester 2 sends arg 16'h0011, k=0 -> req_res_stb = 4'b0100 with req_res_dat 8'h4b, 3 cycles after accept. p becomes 3.
2. Requester 1 sends err 16'hffff -> req_fbk_stb[1] with req_fbk_dat 16'h0000. No result stb asserted.
3. All four requesters send args simultaneously, p=0 -> results returned in order 0,1,2,3, each value matching its own operand. Then with p=3 -> order 3,0,1,2.
4. Requester 0 asserts arg and err together -> the err is served first, then the arg on a later grant. Each produces exactly one response on the correct stream.
5. k=5 stalls with req_res_rdy held low for 4 cycles -> stb and dat held stable. No other requester is granted meanwhile. One-hot property holds every cycle.
6. rst asserted during WAIT -> next cycle all stb/rdy low, state IDLE. A new request afterwards completes normally.
